// File: rtl/symbol_stream_decoder_if.sv
// Bus bundle between the symbol stream decoder and its host/consumer.
// master: the decoder side. slave: the side that loads strings and takes symbols.
interface symbol_stream_decoder_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 6
);
  logic [WIDTH-1:0] string_in;
  logic             load;
  logic             sym_ready;
  logic [2:0]       sym_out;
  logic             sym_valid;
  logic             busy;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] sym_count;

  modport master (
    input  string_in, load, sym_ready,
    output sym_out, sym_valid, busy, done, error, sym_count
  );

  modport slave (
    output string_in, load, sym_ready,
    input  sym_out, sym_valid, busy, done, error, sym_count
  );
endinterface

// File: rtl/symbol_stream_decoder.sv
// Decodes a packed unary-run sequence string (1^k 0 per symbol, oldest symbol
// at the top used bits) into symbol codes 1..4, one bit per clock, MSB-first.
module symbol_stream_decoder #(
  parameter int WIDTH   = 64,
  parameter int MAX_RUN = 4,
  parameter int CNT_W   = 6
) (
  input  logic                    clock,
  input  logic                    reset,
  symbol_stream_decoder_if.master bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SKIP = 3'd1,
    RUN  = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [6:0]       bits_left_q, bits_left_d;
  logic [2:0]       run_q, run_d;
  logic [CNT_W-1:0] sym_count_q, sym_count_d;
  logic [2:0]       sym_out_q, sym_out_d;
  logic             sym_valid_q, sym_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             msb;
  logic [WIDTH-1:0] shreg_shifted;
  logic [6:0]       bits_left_dec;

  assign msb           = shreg_q[WIDTH-1];
  assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
  assign bits_left_dec = bits_left_q - 7'd1;

  // Next-state logic: walk the string one bit per cycle, stall in EMIT until the consumer takes the symbol.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bits_left_d = bits_left_q;
    run_d       = run_q;
    sym_count_d = sym_count_q;
    sym_valid_d = 1'b0;
    sym_out_d   = 3'd0;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.load) begin
          shreg_d     = bus.string_in;
          bits_left_d = 7'(WIDTH);
          run_d       = 3'd0;
          sym_count_d = '0;
          state_d     = SKIP;
        end
      end
      SKIP: begin
        if (bits_left_q == 7'd0) begin
          state_d = DONE;
        end else begin
          shreg_d     = shreg_shifted;
          bits_left_d = bits_left_dec;
          if (msb) begin
            run_d   = 3'd1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (bits_left_q == 7'd0) begin
          // String ended in the middle of a run of ones.
          state_d = ERR;
        end else if (msb) begin
          if (run_q == 3'(MAX_RUN)) begin
            state_d = ERR;
          end else begin
            shreg_d     = shreg_shifted;
            bits_left_d = bits_left_dec;
            run_d       = run_q + 3'd1;
          end
        end else if (run_q == 3'd0) begin
          // A zero right after a terminator: padding is only legal at the top.
          state_d = ERR;
        end else begin
          shreg_d     = shreg_shifted;
          bits_left_d = bits_left_dec;
          sym_valid_d = 1'b1;
          sym_out_d   = run_q;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (bus.sym_ready) begin
          if (sym_count_q != '1) begin
            sym_count_d = sym_count_q + 1'b1;
          end
          run_d   = 3'd0;
          state_d = (bits_left_q == 7'd0) ? DONE : RUN;
        end else begin
          sym_valid_d = 1'b1;
          sym_out_d   = sym_out_q;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d  = (state_d == SKIP) || (state_d == RUN) || (state_d == EMIT);
    done_d  = (state_d == DONE);
    error_d = (state_d == ERR);
  end

  // State and registered outputs; reset aborts any decode in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bits_left_q <= 7'd0;
      run_q       <= 3'd0;
      sym_count_q <= '0;
      sym_out_q   <= 3'd0;
      sym_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bits_left_q <= bits_left_d;
      run_q       <= run_d;
      sym_count_q <= sym_count_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.sym_out   = sym_out_q;
  assign bus.sym_valid = sym_valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.sym_count = sym_count_q;

endmodule

// File: tb/tb_symbol_stream_decoder.sv
// Bench for symbol_stream_decoder: directed strings, scoreboard of expected
// symbol codes checked by an independent monitor on every handshake.
module tb_symbol_stream_decoder;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   stall;
  int   vcnt;
  int   t0;
  logic [2:0] sb[$];
  logic       prev_hold;
  logic [2:0] prev_out;

  symbol_stream_decoder_if #(.WIDTH(64), .CNT_W(6)) bus ();

  symbol_stream_decoder #(.WIDTH(64), .MAX_RUN(4), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Consumer: optionally withholds ready for 'stall' cycles at every symbol.
  initial begin
    bus.sym_ready = 1'b1;
    vcnt = 0;
    forever begin
      @(posedge clock);
      #1;
      if (bus.sym_valid) begin
        vcnt++;
        bus.sym_ready = (vcnt > stall);
      end else begin
        vcnt = 0;
        bus.sym_ready = (stall == 0);
      end
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold-stability under backpressure.
  initial begin
    prev_hold = 1'b0;
    prev_out  = 3'd0;
    forever begin
      @(negedge clock);
      if (prev_hold) begin
        check("hold_valid", {63'd0, bus.sym_valid}, 64'd1);
        check("hold_out", {61'd0, bus.sym_out}, {61'd0, prev_out});
      end
      if (!bus.sym_valid && bus.sym_out !== 3'd0)
        check("out_zero_when_idle", {61'd0, bus.sym_out}, 64'd0);
      if (bus.sym_valid && bus.sym_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_symbol", {61'd0, bus.sym_out}, 64'd0);
        end else begin
          check("symbol", {61'd0, bus.sym_out}, {61'd0, sb.pop_front()});
        end
      end
      prev_hold = bus.sym_valid && !bus.sym_ready && reset;
      prev_out  = bus.sym_out;
    end
  end

  task automatic do_load(input logic [63:0] s);
    @(posedge clock);
    #1;
    bus.string_in = s;
    bus.load      = 1'b1;
    @(posedge clock);
    #1;
    t0 = cyc;
    bus.load = 1'b0;
    check("load_busy", {63'd0, bus.busy}, 64'd1);
    check("load_clears_flags", {62'd0, bus.done, bus.error}, 64'd0);
  endtask

  // Runs one decode to completion; 'disturb' > 0 pulses a stray load at that cycle.
  task automatic run_case(input string name, input logic [63:0] s, input int stall_n,
                          input int disturb, input logic exp_done, input logic exp_err,
                          input int exp_cnt, input int exp_cycles);
    int el;
    bit fin;
    stall = stall_n;
    do_load(s);
    fin = 0;
    el  = 0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(negedge clock);
      el = cyc - t0;
      if (disturb > 0 && el == disturb) begin
        bus.string_in = 64'hFFFF_FFFF_FFFF_FFFF;
        bus.load      = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      if (bus.done || bus.error) fin = 1;
    end
    bus.load = 1'b0;
    if (!fin) check({name, "_timeout"}, 64'd0, 64'd1);
    check({name, "_cycles"}, 64'(el), 64'(exp_cycles));
    check({name, "_done"}, {63'd0, bus.done}, {63'd0, exp_done});
    check({name, "_error"}, {63'd0, bus.error}, {63'd0, exp_err});
    check({name, "_count"}, {58'd0, bus.sym_count}, 64'(exp_cnt));
    check({name, "_busy"}, {63'd0, bus.busy}, 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
    stall = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    stall  = 0;
    bus.string_in = '0;
    bus.load      = 1'b0;
    reset = 1'b0;

    // Reset with random inputs: all outputs must stay low.
    for (int i = 0; i < 4; i++) begin
      @(posedge clock);
      #1;
      bus.string_in = {$urandom, $urandom};
      bus.load      = 1'($urandom_range(0, 1));
      @(negedge clock);
      check("reset_outputs", {55'd0, bus.sym_count, bus.sym_out, bus.sym_valid, bus.busy,
                              bus.done, bus.error}, 64'd0);
    end
    @(posedge clock);
    #1;
    bus.load = 1'b0;
    reset    = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_after_reset", {60'd0, bus.sym_valid, bus.busy, bus.done, bus.error}, 64'd0);

    // Single toggle: valid after edge 64, done after edge 65.
    sb.push_back(3'd1);
    run_case("toggle", 64'h2, 0, 0, 1'b1, 1'b0, 1, 65);

    // Order: toggle, push, mic, mouse.
    sb.push_back(3'd1); sb.push_back(3'd2); sb.push_back(3'd3); sb.push_back(3'd4);
    run_case("order", 64'h2DDE, 0, 0, 1'b1, 1'b0, 4, 68);

    // Backpressure: 5 stall cycles per symbol adds exactly 20 cycles.
    sb.push_back(3'd1); sb.push_back(3'd2); sb.push_back(3'd3); sb.push_back(3'd4);
    run_case("backpressure", 64'h2DDE, 5, 0, 1'b1, 1'b0, 4, 88);

    // Five ones: error when the fifth one reaches the msb, no symbol.
    run_case("five_ones", 64'h3E, 0, 0, 1'b0, 1'b1, 0, 63);

    // Trailing one: one toggle, then error.
    sb.push_back(3'd1);
    run_case("trailing_one", 64'h5, 0, 0, 1'b0, 1'b1, 1, 66);

    // Empty string.
    run_case("empty", 64'h0, 0, 0, 1'b1, 1'b0, 0, 65);

    // Stray load mid-decode is ignored.
    sb.push_back(3'd1); sb.push_back(3'd2); sb.push_back(3'd3); sb.push_back(3'd4);
    run_case("load_midrun", 64'h2DDE, 0, 55, 1'b1, 1'b0, 4, 68);

    // Reset mid-decode aborts immediately, then a fresh decode works.
    sb.push_back(3'd1); sb.push_back(3'd2); sb.push_back(3'd3); sb.push_back(3'd4);
    do_load(64'h2DDE);
    repeat (55) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("midreset_outputs", {55'd0, bus.sym_count, bus.sym_out, bus.sym_valid, bus.busy,
                               bus.done, bus.error}, 64'd0);
    sb.delete();
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check("midreset_idle", {60'd0, bus.sym_valid, bus.busy, bus.done, bus.error}, 64'd0);
    sb.push_back(3'd2);
    run_case("after_reset", 64'h6, 0, 0, 1'b1, 1'b0, 1, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_stream_decoder.md
Name: symbol_stream_decoder

Overview:
- Parses a packed 64-bit sequence string, as produced by the game's input-string encoder, back into symbol codes.
- Encoding: each symbol is a unary run of ones followed by a single zero. toggle=10, push=110, mic=1110, mouse=11110.
- Oldest symbol sits at the most significant used bits. Unused bits are leading zeros.
- The block shifts the string out MSB-first, one bit per clock, and emits codes 1..4 over a valid/ready handshake. The sequence player and the answer checker consume these codes.

Parameters:
- WIDTH, 64, string width in bits.
- MAX_RUN, 4, longest legal run of ones (mouse).
- CNT_W, 6, width of the symbol counter; must hold WIDTH/2.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- string_in  input  WIDTH  packed sequence; sampled only on an accepted load.
- load  input  1  start decode; accepted only in IDLE, DONE or ERR.
- sym_ready  input  1  consumer accepts sym_out this cycle.
- sym_out  output  3  symbol code: 1 toggle, 2 push, 3 mic, 4 mouse; 0 when sym_valid is low.
- sym_valid  output  1  sym_out holds a decoded symbol.
- busy  output  1  high in SKIP, RUN and EMIT.
- done  output  1  level, high in DONE.
- error  output  1  level, high in ERR; sticky until load or reset.
- sym_count  output  CNT_W  number of symbols handed off since the last load.

Behaviour:
- Reset (async, reset=0): state IDLE. shreg=0, bits_left=0, run=0, sym_count=0. All outputs 0.
- Internal registers:
  - shreg[WIDTH-1:0]; "msb" below means shreg[WIDTH-1].
  - bits_left, 7 bits.
  - run, 3 bits.
- Every "consume" shifts shreg left by 1, zero-fills, and decrements bits_left.
- IDLE / DONE / ERR:
  - On load: shreg=string_in, bits_left=WIDTH, run=0, sym_count=0, done and error cleared. Next state SKIP.
  - Otherwise hold state.
- SKIP:
  - bits_left==0 -> DONE.
  - msb==0 -> consume, stay.
  - msb==1 -> consume, run=1, go RUN.
- RUN:
  - bits_left==0 -> ERR (string ends in ones).
  - msb==1 with run==MAX_RUN -> ERR (no consume).
  - msb==1 otherwise -> consume, run=run+1.
  - msb==0 with run==0 -> ERR (stray zero between symbols).
  - msb==0 otherwise -> consume, go EMIT.
- EMIT:
  - sym_valid=1 and sym_out=run. Both are held stable, and no shifting occurs, until sym_ready.
  - On sym_ready: sym_count+1, run=0. Then bits_left==0 -> DONE, else -> RUN.
- Latency for the first symbol with z leading zeros and a k-one run: sym_valid is high after rising edge z+k+1 counted from the load-sampling edge (edge 0).
- With sym_ready held high, each subsequent symbol costs its k+1 bits plus 1 handshake cycle.
- load while busy is ignored; the decode continues unaffected.
- sym_count saturates at 2^CNT_W-1. This is unreachable for legal 64-bit strings (at most 32 symbols).
- A truncated oldest symbol (encoder overflow) is not detectable. It decodes as whatever run remains.
- Reset asserted mid-decode aborts immediately to reset values. No symbol is emitted after deassertion until a new load.

Test Plan:
- Reset check: reset=0 with random inputs -> all outputs 0, busy=0. After release, stays IDLE with no load.
- Single toggle: load string_in=64'h2, sym_ready=1 -> sym_valid=1, sym_out=1 after edge 64. On the next edge: done=1, sym_count=1, busy=0.
- Order check: string_in=64'h2DDE (10_110_1110_11110), sym_ready=1 -> codes 1,2,3,4 in that order. Then done=1, sym_count=4, error=0.
- Backpressure: same string with sym_ready=0 for 5 cycles at each EMIT -> sym_valid and sym_out stay constant, no bit consumed. Final sym_count=4, and total cycles increase by exactly 20.
- Errors:
  - 64'h3E (five ones) -> error=1 when the fifth one is at msb; sym_valid never asserts.
  - 64'h5 (ends in 1) -> one toggle emitted, then error=1.
  - 64'h0 -> done=1 after edge 65, sym_count=0.
- Control: load pulsed mid-decode -> ignored, output identical to an undisturbed run. reset pulsed mid-decode -> immediate IDLE; a new load decodes cleanly.
